// File: rtl/io_uart_if.sv
// CPU-side I/O bus bundle for the io_uart peripheral: single-cycle read/write
// strobes, full byte address, write data and registered read data.
interface io_uart_if;
    logic        io_write_en;
    logic        io_read_en;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;

    modport master (
        output io_write_en, io_read_en, io_address, io_write_data,
        input  io_read_data
    );

    modport slave (
        input  io_write_en, io_read_en, io_address, io_write_data,
        output io_read_data
    );
endinterface

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: STATUS / RX_DATA / TX_DATA registers, a single-byte
// transmitter, and a receiver feeding a small RX FIFO.
//   state    | meaning
//   TX_IDLE  | line high, ready to accept a TX_DATA write
//   TX_START | driving the start bit (low)
//   TX_DATA  | shifting 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (high)
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | counting to mid start bit, rejecting glitches
//   RX_DATA  | sampling 8 data bits once per bit period
//   RX_STOP  | sampling the stop bit, push or flag frame error
//   RX_WAIT  | after a framing error, waiting for the line to return high
module io_uart #(
    parameter logic [31:0] BASE_ADDRESS  = 32'hFFFF0040,
    parameter int          BAUD_DIVIDE   = 27,
    parameter int          RX_FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    io_uart_if.slave bus,
    output logic     uart_tx,
    input  logic     uart_rx
);
    localparam int CW = $clog2(BAUD_DIVIDE);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIVIDE - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(BAUD_DIVIDE / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          rx_push, frame_set;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic          fifo_empty, fifo_full, pop_en, push_en, overrun_set;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic sel_status, sel_rxdata, sel_txdata, rd_status, rd_rxdata, wr_txdata, tx_ready;
    logic unused_wdata;

    assign sel_status = (bus.io_address == BASE_ADDRESS);
    assign sel_rxdata = (bus.io_address == BASE_ADDRESS + 32'd4);
    assign sel_txdata = (bus.io_address == BASE_ADDRESS + 32'd8);
    assign rd_status  = bus.io_read_en & sel_status;
    assign rd_rxdata  = bus.io_read_en & sel_rxdata;
    assign wr_txdata  = bus.io_write_en & sel_txdata;
    assign tx_ready   = (tx_state_q == TX_IDLE);
    assign unused_wdata = ^bus.io_write_data[31:8];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            TX_IDLE: if (wr_txdata) begin
                tx_state_d = TX_START;
                tx_shift_d = bus.io_write_data[7:0];
                tx_cnt_d   = BIT_LAST;
                tx_line_d  = 1'b0;
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = BIT_LAST;
                tx_bit_d   = 3'd0;
                tx_line_d  = tx_shift_q[0];
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_LAST;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_line_d  = tx_shift_q[1];
                end
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            TX_STOP: if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
                     else tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = BIT_HALF;
            end
            RX_START: if (rx_cnt_q == '0) begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
                else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = BIT_LAST;
                    rx_bit_d   = 3'd0;
                end
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_cnt_d   = BIT_LAST;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_STOP: if (rx_cnt_q == '0) begin
                if (rx_sync_q) begin
                    rx_push    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    frame_set  = 1'b1;
                    rx_state_d = RX_WAIT;
                end
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            RX_WAIT: if (rx_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_en      = rd_rxdata & ~fifo_empty;
    assign push_en     = rx_push & (~fifo_full | pop_en);
    assign overrun_set = rx_push & fifo_full & ~pop_en;
    assign wr_ptr_d    = wr_ptr_q + (AW+1)'(push_en);
    assign rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_en);
    assign overrun_d   = (overrun_q & ~rd_status) | overrun_set;
    assign frame_err_d = (frame_err_q & ~rd_status) | frame_set;

    always_comb begin
        rdata_d = rdata_q;
        if (bus.io_read_en) begin
            rdata_d = '0;
            if (sel_status) rdata_d[3:0] = {frame_err_q, overrun_q, ~fifo_empty, tx_ready};
            else if (sel_rxdata && !fifo_empty) rdata_d[7:0] = fifo_mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_line_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) fifo_mem[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    assign uart_tx          = tx_line_q;
    assign bus.io_read_data = rdata_q;
endmodule
